// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter: source indices,
// register-file widths and the buffered result entry.
package writeback_arbiter_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_ADR_W = 5;

    localparam int unsigned WB_SRC_ALU = 0;
    localparam int unsigned WB_SRC_MDU = 1;
    localparam int unsigned WB_SRC_LSU = 2;
    localparam int unsigned WB_SRC_CSR = 3;
    localparam int unsigned WB_NSRC    = 4;

    typedef struct packed {
        logic [REG_ADR_W-1:0] adr;
        logic [XLEN-1:0]      data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Result-source handshake and register-file write port of the writeback arbiter.
interface writeback_arbiter_if
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned NSRC = WB_NSRC
);

    logic [NSRC-1:0]                src_v_i;
    logic [NSRC-1:0][XLEN-1:0]      src_data_i;
    logic [NSRC-1:0][REG_ADR_W-1:0] src_adr_i;
    logic [NSRC-1:0]                src_ready_o;
    logic                           res_v;
    logic [REG_ADR_W-1:0]           res_adr;
    logic [XLEN-1:0]                res_data;
    logic                           busy_o;

    // Calculation units / register manager side
    modport master (
        output src_v_i, src_data_i, src_adr_i,
        input  src_ready_o, res_v, res_adr, res_data, busy_o
    );

    // Arbiter side
    modport slave (
        input  src_v_i, src_data_i, src_adr_i,
        output src_ready_o, res_v, res_adr, res_data, busy_o
    );

endinterface

// File: rtl/writeback_arbiter_wb_src_fifo.sv
// Per-source result buffer: DEPTH-entry FIFO of wb_entry_t. Push while full
// and pop while empty are ignored.
module wb_src_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  wb_entry_t        entry_i,
    input  logic             pop_i,
    output wb_entry_t        head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // DEPTH is a power of two, so the pointers wrap on natural overflow
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = entry_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only entries below count are ever read
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Serialises buffered unit results onto the single register-file write port,
// round-robin. Optional WRITEBACK_ARBITER_BYPASS_EN lets an empty source's
// incoming result compete for the port in the same cycle.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned NSRC  = WB_NSRC,
    parameter int unsigned DEPTH = 2
) (
    input logic                clk,
    input logic                rst,
    writeback_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t            head   [NSRC];
    wb_entry_t            cand   [NSRC];
    logic [CNT_W-1:0]     count  [NSRC];
    logic [NSRC-1:0]      empty, full, push, pop, req, src_ready;

    logic                 grant;
    logic [IDX_W-1:0]     gidx;
    wb_entry_t            sel;

    logic [IDX_W-1:0]     rr_q, rr_d;
    logic                 res_v_q, res_v_d;
    logic [REG_ADR_W-1:0] res_adr_q, res_adr_d;
    logic [XLEN-1:0]      res_data_q, res_data_d;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        wb_entry_t in_entry;
        logic      byp_take;

        assign in_entry = '{adr: bus.src_adr_i[g], data: bus.src_data_i[g]};

        // Ready depends only on the registered count
        assign src_ready[g] = (count[g] < CNT_W'(DEPTH));

`ifdef WRITEBACK_ARBITER_BYPASS_EN
        // An empty buffer offers the incoming result; a non-empty one its head
        assign req[g]   = ~empty[g] | bus.src_v_i[g];
        assign cand[g]  = empty[g] ? in_entry : head[g];
        assign byp_take = grant & (gidx == IDX_W'(g)) & empty[g];
`else
        assign req[g]   = ~empty[g];
        assign cand[g]  = head[g];
        assign byp_take = 1'b0;
`endif

        assign push[g] = bus.src_v_i[g] & ~full[g] & ~byp_take;
        assign pop[g]  = grant & (gidx == IDX_W'(g)) & ~empty[g];

        wb_src_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[g]),
            .entry_i (in_entry),
            .pop_i   (pop[g]),
            .head_o  (head[g]),
            .count_o (count[g]),
            .empty_o (empty[g]),
            .full_o  (full[g])
        );
    end

    // Cyclic scan for the first requester at or after rr_q
    always_comb begin
        int unsigned      idx;
        logic [IDX_W-1:0] cidx;
        grant = 1'b0;
        gidx  = '0;
        idx   = 0;
        cidx  = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= NSRC) begin
                idx = idx - NSRC;
            end
            cidx = IDX_W'(idx);
            if (!grant && req[cidx]) begin
                grant = 1'b1;
                gidx  = cidx;
            end
        end
    end

    // Output register; an x0 entry consumes its slot without a write strobe
    always_comb begin
        sel        = cand[gidx];
        rr_d       = rr_q;
        res_v_d    = 1'b0;
        res_adr_d  = res_adr_q;
        res_data_d = res_data_q;
        if (grant) begin
            rr_d       = (gidx == IDX_W'(NSRC - 1)) ? '0 : gidx + IDX_W'(1);
            res_v_d    = (sel.adr != REG_ADR_W'(0));
            res_adr_d  = sel.adr;
            res_data_d = sel.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= '0;
            res_v_q    <= 1'b0;
            res_adr_q  <= '0;
            res_data_q <= '0;
        end else begin
            rr_q       <= rr_d;
            res_v_q    <= res_v_d;
            res_adr_q  <= res_adr_d;
            res_data_q <= res_data_d;
        end
    end

    assign bus.src_ready_o = src_ready;
    assign bus.res_v       = res_v_q;
    assign bus.res_adr     = res_adr_q;
    assign bus.res_data    = res_data_q;
    assign bus.busy_o      = (|(~empty)) | res_v_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter: reset, latency,
// round-robin order, backpressure, x0 suppression and mid-run reset.
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

`ifdef WRITEBACK_ARBITER_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    writeback_arbiter_if #(.NSRC(4)) bus ();

    writeback_arbiter #(
        .NSRC  (4),
        .DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.src_v_i = '0;
    endtask

    task automatic drive(input int i, input logic [4:0] adr, input logic [31:0] data);
        bus.src_v_i[i]    = 1'b1;
        bus.src_adr_i[i]  = adr;
        bus.src_data_i[i] = data;
    endtask

    task automatic expect_write(input string tag, input logic [4:0] adr, input logic [31:0] data);
        check({tag, "_v"},    64'(bus.res_v),    64'd1);
        check({tag, "_adr"},  64'(bus.res_adr),  64'(adr));
        check({tag, "_data"}, 64'(bus.res_data), 64'(data));
    endtask

    // Single source result, written LAT cycles after its handshake edge
    task automatic single(input string tag, input int i, input logic [4:0] adr, input logic [31:0] data);
        drive(i, adr, data);
        tick();
        idle();
        repeat (LAT - 1) tick();
        expect_write(tag, adr, data);
        tick();
        check({tag, "_done"}, 64'(bus.res_v), 64'd0);
    endtask

    // All four sources push adr=i+1; writes follow from index 'first' cyclically
    task automatic burst(input string tag, input int first, input logic [31:0] seed);
        for (int i = 0; i < 4; i++) drive(i, 5'(i + 1), seed + 32'(i));
        tick();
        idle();
        repeat (LAT - 1) tick();
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (first + k) % 4;
            expect_write($sformatf("%s_%0d", tag, k), 5'(idx + 1), seed + 32'(idx));
            tick();
        end
        check({tag, "_end"}, 64'(bus.res_v), 64'd0);
    endtask

    initial begin
        logic [31:0] lsu_data [3];
        int a_idx, l_idx, a_wr, l_wr;
        logic a_acc, l_acc;

        errors = 0;
        checks = 0;
        rst    = 1'b1;
        bus.src_v_i    = '0;
        bus.src_adr_i  = '0;
        bus.src_data_i = '0;

        // Reset held with all valids high
        for (int i = 0; i < 4; i++) drive(i, 5'(i + 20), 32'h5555_0000 + 32'(i));
        tick();
        tick();
        check("rst_res_v",   64'(bus.res_v),       64'd0);
        check("rst_ready",   64'(bus.src_ready_o), 64'hF);
        check("rst_busy",    64'(bus.busy_o),      64'd0);
        check("rst_adr",     64'(bus.res_adr),     64'd0);
        check("rst_data",    64'(bus.res_data),    64'd0);
        rst = 1'b0;
        idle();
        tick();
        check("post_rst_res_v", 64'(bus.res_v),  64'd0);
        check("post_rst_busy",  64'(bus.busy_o), 64'd0);

        // Single ALU result, latency check
        drive(WB_SRC_ALU, 5'd5, 32'hDEADBEEF);
        tick();
        idle();
`ifdef WRITEBACK_ARBITER_BYPASS_EN
        expect_write("alu_single", 5'd5, 32'hDEADBEEF);
`else
        check("alu_lat_v",    64'(bus.res_v),  64'd0);
        check("alu_lat_busy", 64'(bus.busy_o), 64'd1);
        tick();
        expect_write("alu_single", 5'd5, 32'hDEADBEEF);
`endif
        tick();
        check("alu_single_done", 64'(bus.res_v), 64'd0);

        // CSR write brings rr_ptr back to 0
        single("csr_single", WB_SRC_CSR, 5'd10, 32'h0000_CC10);

        burst("burst1", 0, 32'h1111_0000);
        burst("burst2", 0, 32'h2222_0000);
        single("lsu_single", WB_SRC_LSU, 5'd7, 32'h0000_7777);
        burst("burst3", 3, 32'h3333_0000);

        // Backpressure: ALU saturates the port while LSU pushes three results
        lsu_data[0] = 32'hC300_0001;
        lsu_data[1] = 32'hC300_0002;
        lsu_data[2] = 32'hC300_0003;
        a_idx = 0; l_idx = 0; a_wr = 0; l_wr = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus.res_v) begin
                if (bus.res_adr == 5'd3) begin
                    check($sformatf("bp_lsu_%0d", l_wr), 64'(bus.res_data),
                          (l_wr < 3) ? 64'(lsu_data[l_wr]) : 64'hFFFF_FFFF_FFFF);
                    l_wr++;
                end else begin
                    check($sformatf("bp_alu_%0d", a_wr), 64'(bus.res_data),
                          64'(32'hA100_0000 + 32'(a_wr)));
                    check("bp_alu_adr", 64'(bus.res_adr), 64'd1);
                    a_wr++;
                end
            end
`ifndef WRITEBACK_ARBITER_BYPASS_EN
            if (c == 2) begin
                check("bp_lsu_full",    64'(bus.src_ready_o[WB_SRC_LSU]), 64'd0);
                check("bp_lsu_pending", 64'(l_idx), 64'd2);
            end
`endif
            idle();
            if (a_idx < 6) drive(WB_SRC_ALU, 5'd1, 32'hA100_0000 + 32'(a_idx));
            if (l_idx < 3) drive(WB_SRC_LSU, 5'd3, lsu_data[l_idx]);
            a_acc = bus.src_v_i[WB_SRC_ALU] & bus.src_ready_o[WB_SRC_ALU];
            l_acc = bus.src_v_i[WB_SRC_LSU] & bus.src_ready_o[WB_SRC_LSU];
            tick();
            if (a_acc) a_idx++;
            if (l_acc) l_idx++;
        end
        idle();
        check("bp_lsu_accepted", 64'(l_idx), 64'd3);
        check("bp_lsu_written",  64'(l_wr),  64'd3);
        check("bp_alu_written",  64'(a_wr),  64'd6);
        check("bp_idle_busy",    64'(bus.busy_o), 64'd0);

        // x0 result: slot consumed, no write strobe
        drive(WB_SRC_MDU, 5'd0, 32'd7);
        tick();
        idle();
`ifdef WRITEBACK_ARBITER_BYPASS_EN
        check("x0_v",    64'(bus.res_v),  64'd0);
        check("x0_busy", 64'(bus.busy_o), 64'd0);
`else
        check("x0_v_early",    64'(bus.res_v),  64'd0);
        check("x0_busy_early", 64'(bus.busy_o), 64'd1);
        tick();
        check("x0_v",    64'(bus.res_v),  64'd0);
        check("x0_busy", 64'(bus.busy_o), 64'd0);
`endif
        tick();
        check("x0_v_late", 64'(bus.res_v), 64'd0);
        single("mdu_after_x0", WB_SRC_MDU, 5'd9, 32'h0000_0099);

        // Reset with three buffered results
        drive(WB_SRC_ALU, 5'd11, 32'h0000_0B0B);
        drive(WB_SRC_MDU, 5'd12, 32'h0000_0C0C);
        drive(WB_SRC_LSU, 5'd13, 32'h0000_0D0D);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_res_v", 64'(bus.res_v),       64'd0);
        check("mid_rst_ready", 64'(bus.src_ready_o), 64'hF);
        check("mid_rst_busy",  64'(bus.busy_o),      64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("mid_rst_quiet_%0d", k), 64'(bus.res_v), 64'd0);
        end
        check("mid_rst_busy_end", 64'(bus.busy_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
